// File: rtl/beta_if_fetch_unit.sv
// beta_if_fetch_unit -- instruction fetch front end of the beta core.
//
// Owns the PC and issues word requests to instruction memory over a
// req/gnt/rvalid protocol. Returned words are paired with the PC they
// were requested at and buffered in a small FIFO. Decode drains the FIFO
// through a valid/ready handshake. A branch redirects the PC, flushes the
// FIFO and marks every response still in flight to be discarded.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   fetch_en_i             permits issuing new requests
//   branch_i               one-cycle redirect strobe
//   branch_target_i        redirect PC (low two bits ignored)
//   instr_req_o            memory request
//   instr_addr_o           word-aligned request address
//   instr_gnt_i            request accepted this cycle
//   instr_rvalid_i         in-order response valid
//   instr_rdata_i          response instruction word
//   instr_err_i            bus error, qualified by rvalid
//   if_valid_o             FIFO head valid for decode
//   if_instr_o, if_pc_o    head instruction and its PC
//   if_err_o               head carries a fetch error
//   dec_ready_i            decode accepts the head
module beta_if_fetch_unit #(
  parameter int              XLEN            = 32,
  parameter int              FIFO_DEPTH      = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] BOOT_ADDR       = 32'h0000_0080
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            fetch_en_i,
  input  logic            branch_i,
  input  logic [XLEN-1:0] branch_target_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [31:0]     instr_rdata_i,
  input  logic            instr_err_i,
  output logic            if_valid_o,
  output logic [31:0]     if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic            if_err_o,
  input  logic            dec_ready_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_STALL} state_t;

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic            r_pend;               // request raised, not yet granted
  logic [OW-1:0]   r_out, r_disc, w_out_nxt;

  // PC of every granted request, consumed in order by responses
  logic [XLEN-1:0] r_tag [MAX_OUTSTANDING];
  logic [TW-1:0]   r_tag_wr, r_tag_rd;

  logic [31:0]     r_f_instr [FIFO_DEPTH];
  logic [XLEN-1:0] r_f_pc    [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_f_err;
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_cnt;

  logic w_credit, w_acc, w_rv, w_drop, w_push, w_pop;
  logic w_unused_tgt;

  assign w_unused_tgt = ^branch_target_i[1:0];

  // Responses that are neither buffered nor discarded still need a FIFO
  // slot, so they count against the buffer space alongside the FIFO itself.
  assign w_credit = (r_out < OW'(MAX_OUTSTANDING)) &&
                    ((SW'(r_cnt) + SW'(r_out - r_disc)) < SW'(FIFO_DEPTH));

  assign instr_req_o  = r_pend | ((r_state == S_FETCH) & w_credit & fetch_en_i);
  assign instr_addr_o = r_pc;

  assign w_acc  = instr_req_o & instr_gnt_i;
  // a response with nothing outstanding cannot be ours
  assign w_rv   = instr_rvalid_i & (r_out != '0);
  assign w_drop = w_rv & (branch_i | (r_disc != '0));
  assign w_push = w_rv & ~w_drop;
  assign w_pop  = if_valid_o & dec_ready_i & ~branch_i;

  assign w_out_nxt = r_out + OW'(w_acc) - OW'(w_rv);

  assign if_valid_o = (r_cnt != '0);
  assign if_instr_o = r_f_instr[r_rd];
  assign if_pc_o    = r_f_pc[r_rd];
  assign if_err_o   = r_f_err[r_rd];

  always_comb begin
    w_state_nxt = r_state;
    if (!fetch_en_i && !r_pend) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (fetch_en_i) w_state_nxt = S_FETCH;
        S_FETCH: if (!w_credit)  w_state_nxt = S_STALL;
        S_STALL: if (w_credit)   w_state_nxt = S_FETCH;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_pc     <= BOOT_ADDR;
      r_pend   <= 1'b0;
      r_out    <= '0;
      r_disc   <= '0;
      r_tag_wr <= '0;
      r_tag_rd <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) r_tag[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      // a redirect may retract an ungranted request
      r_pend  <= branch_i ? 1'b0 : (instr_req_o & ~instr_gnt_i);
      if (branch_i)   r_pc <= {branch_target_i[XLEN-1:2], 2'b00};
      else if (w_acc) r_pc <= r_pc + XLEN'(4);
      r_out <= w_out_nxt;
      // everything still outstanding after this cycle, including a grant
      // taken in the branch cycle itself, belongs to the old path
      if (branch_i)                  r_disc <= w_out_nxt;
      else if (w_rv && r_disc != '0) r_disc <= r_disc - OW'(1);
      if (w_acc) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr <= (r_tag_wr == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tag_wr + TW'(1);
      end
      if (w_rv)
        r_tag_rd <= (r_tag_rd == TW'(MAX_OUTSTANDING - 1)) ? '0 : r_tag_rd + TW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_f_err <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_f_instr[i] <= '0;
        r_f_pc[i]    <= '0;
      end
    end else if (branch_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_f_instr[r_wr] <= instr_rdata_i;
        r_f_pc[r_wr]    <= r_tag[r_tag_rd];
        r_f_err[r_wr]   <= instr_err_i;
        r_wr            <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // credit accounting must never let a response land on a full buffer
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && (r_cnt == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_beta_if_fetch_unit.sv
// tb_beta_if_fetch_unit -- self-checking bench for beta_if_fetch_unit.
//
// Memory is modelled as an in-order responder whose words are a fixed
// function of the address. The reference model keeps only the expected
// next request address and the expected next PC seen by decode: both
// advance by 4 and jump to the (aligned) target on a branch, so any stale
// word, reordering or wrong pairing shows up as a stream break.
module tb_beta_if_fetch_unit;
  localparam int          MAXO  = 2;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0080;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1, fetch_en_i = 1'b0, branch_i = 1'b0, dec_ready_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        instr_req_o, instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
  logic [31:0] instr_addr_o, instr_rdata_i = '0;
  logic        if_valid_o, if_err_o;
  logic [31:0] if_instr_o, if_pc_o;

  always #5 clk_i = ~clk_i;

  beta_if_fetch_unit #(.XLEN(32), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .BOOT_ADDR(BOOT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .fetch_en_i(fetch_en_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .if_valid_o(if_valid_o), .if_instr_o(if_instr_o),
    .if_pc_o(if_pc_o), .if_err_o(if_err_o), .dec_ready_i(dec_ready_i));

  typedef struct { logic [31:0] a; int due; } rsp_t;
  rsp_t mq[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_due = -1, n_gnt = 0, n_pop = 0;
  int gnt_prob = 100, gnt_block = 0, lat_min = 1, lat_max = 1;
  logic [31:0] m_pc = BOOT, exp_dec = BOOT, prev_addr = '0;
  logic        prev_pend = 1'b0, prev_br = 1'b0, s_vld;
  logic        cap_g_arm = 1'b0, cap_d_arm = 1'b0;
  logic [31:0] cap_g = '0, cap_d = '0;
  logic        log_req [256];
  logic        log_vld [256];
  logic [31:0] log_addr [256];
  logic [31:0] log_pc [256];

  function automatic logic [31:0] mdata(logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction
  function automatic logic merr(logic [31:0] a);
    return a[5:2] == 4'h1;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: caller has set the control inputs at the falling edge.
  task automatic tick();
    logic req, gnt, rv;
    logic [31:0] addr;
    int due;
    #1;
    req = instr_req_o; addr = instr_addr_o; s_vld = if_valid_o;
    if (cyc < 256) begin
      log_req[cyc] = req; log_addr[cyc] = addr; log_vld[cyc] = s_vld; log_pc[cyc] = if_pc_o;
    end
    rv = 1'b0; gnt = 1'b0;
    if (!rst_i) begin
      if (mq.size() > 0 && mq[0].due <= cyc) rv = 1'b1;
      if (req) begin
        if (gnt_block > 0) gnt_block--;
        else gnt = ($urandom_range(99) < gnt_prob);
      end
    end
    instr_gnt_i    = gnt;
    instr_rvalid_i = rv;
    instr_rdata_i  = rv ? mdata(mq[0].a) : $urandom;
    instr_err_i    = rv ? merr(mq[0].a) : 1'($urandom_range(1));
    if (!rst_i) begin
      if (prev_pend) begin
        chk("req_hold", 32'(req), 32'd1);
        chk("hold_addr", addr, prev_addr);
      end
      if (prev_br) chk("vld_after_br", 32'(s_vld), 32'd0);
      if (req) chk("req_addr", addr, m_pc);
      if (s_vld && dec_ready_i && !branch_i) begin
        chk("dec_pc", if_pc_o, exp_dec);
        chk("dec_instr", if_instr_o, mdata(exp_dec));
        chk("dec_err", 32'(if_err_o), 32'(merr(exp_dec)));
        if (cap_d_arm) begin cap_d = if_pc_o; cap_d_arm = 1'b0; end
        exp_dec += 32'd4;
        n_pop++;
      end
      if (rv) void'(mq.pop_front());
      if (gnt) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr, due});
        chk("outstanding_le_max", 32'(mq.size() <= MAXO), 32'd1);
        n_gnt++;
        if (cap_g_arm) begin cap_g = addr; cap_g_arm = 1'b0; end
      end
      if (branch_i) begin
        m_pc    = {branch_target_i[31:2], 2'b00};
        exp_dec = m_pc;
      end else if (gnt) m_pc += 32'd4;
      prev_pend = req && !gnt && !branch_i;
      prev_addr = addr;
      prev_br   = branch_i;
    end else begin
      mq.delete();
      m_pc = BOOT; exp_dec = BOOT; prev_pend = 1'b0; prev_br = 1'b0; last_due = -1;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0;
  endtask

  task automatic do_reset(bit check);
    rst_i = 1'b1; fetch_en_i = 1'b0; branch_i = 1'b0; dec_ready_i = 1'b0;
    tick(); tick();
    if (check) begin
      #1;
      chk("rst_req", 32'(instr_req_o), 32'd0);
      chk("rst_addr", instr_addr_o, BOOT);
      chk("rst_vld", 32'(if_valid_o), 32'd0);
      chk("rst_instr", if_instr_o, 32'd0);
      chk("rst_pc", if_pc_o, 32'd0);
      chk("rst_err", 32'(if_err_o), 32'd0);
    end
    rst_i = 1'b0;
    cyc = 0; n_gnt = 0; last_due = -1;
  endtask

  initial begin
    @(negedge clk_i);

    // streaming fetch, grant always, response one cycle later
    do_reset(1'b1);
    fetch_en_i = 1'b1; dec_ready_i = 1'b1; gnt_prob = 100; lat_min = 1; lat_max = 1;
    repeat (10) tick();
    chk("t1_req0", 32'(log_req[0]), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      chk("t1_req", 32'(log_req[i]), 32'd1);
      chk("t1_addr", log_addr[i], BOOT + 32'(4 * (i - 1)));
    end
    chk("t1_vld_early", 32'(log_vld[2]), 32'd0);
    chk("t1_vld", 32'(log_vld[3]), 32'd1);
    chk("t1_first_pc", log_pc[3], BOOT);

    // decode back-pressure fills the buffer and stalls fetching
    do_reset(1'b0);
    fetch_en_i = 1'b1; dec_ready_i = 1'b0;
    repeat (12) tick();
    chk("t2_grants", 32'(n_gnt), 32'(DEPTH));
    chk("t2_req_stall", 32'(log_req[11]), 32'd0);
    chk("t2_vld", 32'(log_vld[11]), 32'd1);
    chk("t2_head", log_pc[11], BOOT);
    dec_ready_i = 1'b1; cap_g_arm = 1'b1;
    repeat (12) tick();
    chk("t2_resume", cap_g, BOOT + 32'h10);

    // redirect with two requests in flight
    do_reset(1'b0);
    fetch_en_i = 1'b1; dec_ready_i = 1'b1; lat_min = 3; lat_max = 3;
    for (int k = 0; k < 20 && mq.size() < 2; k++) tick();
    chk("t3_outst", 32'(mq.size()), 32'd2);
    branch_i = 1'b1; branch_target_i = 32'h0000_0203;
    tick();
    branch_i = 1'b0; cap_g_arm = 1'b1; cap_d_arm = 1'b1;
    repeat (15) tick();
    chk("t3_new_addr", cap_g, 32'h200);
    chk("t3_new_pc", cap_d, 32'h200);

    // redirect in the same cycle as a grant and a response
    do_reset(1'b0);
    fetch_en_i = 1'b1; dec_ready_i = 1'b1; lat_min = 1; lat_max = 1;
    repeat (4) tick();
    chk("t4_req", 32'(instr_req_o), 32'd1);
    chk("t4_rv_due", 32'(mq.size() > 0 && mq[0].due <= cyc), 32'd1);
    branch_i = 1'b1; branch_target_i = 32'h0000_0400;
    tick();
    branch_i = 1'b0; cap_g_arm = 1'b1; cap_d_arm = 1'b1;
    repeat (8) tick();
    chk("t4_new_addr", cap_g, 32'h400);
    chk("t4_new_pc", cap_d, 32'h400);

    // delayed grant, then reset while a request waits
    do_reset(1'b0);
    fetch_en_i = 1'b1; dec_ready_i = 1'b1; gnt_block = 3;
    repeat (6) tick();
    chk("t6_dly_req", 32'(log_req[3]), 32'd1);
    chk("t6_dly_addr", log_addr[3], BOOT);
    chk("t6_after_gnt", log_addr[5], BOOT + 32'd4);
    gnt_prob = 0;
    repeat (3) tick();
    do_reset(1'b0);
    fetch_en_i = 1'b1; gnt_prob = 100; cap_g_arm = 1'b1;
    repeat (6) tick();
    chk("t6_rst_addr", cap_g, BOOT);

    // randomized traffic
    do_reset(1'b0);
    n_pop = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        gnt_prob = $urandom_range(100, 30);
        lat_min  = $urandom_range(2, 1);
        lat_max  = lat_min + $urandom_range(2);
      end
      fetch_en_i  = ($urandom_range(15) != 0);
      dec_ready_i = ($urandom_range(3) != 0);
      branch_i    = ($urandom_range(31) == 0) || (prev_br && $urandom_range(3) == 0);
      branch_target_i = ($urandom_range(7) == 0) ? 32'hFFFF_FFF5 : $urandom;
      tick();
    end
    branch_i = 1'b0;
    chk("progress", 32'(n_pop > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
